// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter decoder.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    WGAP  = 2'd3
  } state_t;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

endpackage

// File: rtl/morse_tick_timer.sv
// Restartable tick generator: one tick every TICK_CYCLES clocks, phase
// realigned whenever clear_i is asserted.
module morse_tick_timer #(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and tick: clear wins, terminal count wraps to zero.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      tick_o = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/morse_letter_decoder.sv
// Morse key decoder: times key presses and gaps in tick units, classifies
// dots/dashes, packs them into a letter code and flags letter/word gaps.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no pending symbols, key released
// PRESS | key held, measuring press length
// GAP   | key released with symbols pending, waiting for letter gap
// WGAP  | letter emitted, waiting for word gap or next press
module morse_letter_decoder
  import morse_pkg::*;
#(
  parameter int TICK_CYCLES      = 5_000_000,
  parameter int DASH_TICKS       = 4,
  parameter int LETTER_GAP_TICKS = 6,
  parameter int WORD_GAP_TICKS   = 14,
  parameter int MAX_SYMBOLS      = 6,
  parameter int CNT_W            = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 b,
  output logic                                 dot,
  output logic                                 dash,
  output logic                                 code_valid,
  output logic [MAX_SYMBOLS-1:0]               code_bits,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]     code_len,
  output logic                                 code_err,
  output logic                                 word_gap
);

  localparam int LEN_W = $clog2(MAX_SYMBOLS + 1);
  localparam logic [CNT_W-1:0] DASH_T = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LGAP_T = CNT_W'(LETTER_GAP_TICKS);
  localparam logic [CNT_W-1:0] WGAP_T = CNT_W'(WORD_GAP_TICKS);
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_SYMBOLS);

  logic b_meta_q, b_s_q, b_d_q, rise_q, fall_q;
  logic edge_any, tick;
  logic [CNT_W-1:0] dur_q, dur_d;

  state_t state_q, state_d;
  logic [MAX_SYMBOLS-1:0] acc_bits_q, acc_bits_d;
  logic [LEN_W-1:0]       acc_len_q, acc_len_d;
  logic                   err_q, err_d;

  logic dot_q, dot_d, dash_q, dash_d, cv_q, cv_d, wg_q, wg_d;
  logic [MAX_SYMBOLS-1:0] code_bits_q, code_bits_d;
  logic [LEN_W-1:0]       code_len_q, code_len_d;
  logic                   code_err_q, code_err_d;
  logic                   sym;

  // Synchronize the key and register its edges; the edge register adds one
  // stage so dot/dash land four edges after the key is first sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_meta_q <= 1'b0;
      b_s_q    <= 1'b0;
      b_d_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      b_meta_q <= b;
      b_s_q    <= b_meta_q;
      b_d_q    <= b_s_q;
      rise_q   <= b_s_q & ~b_d_q;
      fall_q   <= ~b_s_q & b_d_q;
    end
  end

  assign edge_any = rise_q | fall_q;

  morse_tick_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (edge_any),
    .tick_o  (tick)
  );

  // Press/gap duration in ticks, restarted on every key edge, saturating.
  always_comb begin
    dur_d = dur_q;
    if (edge_any)                  dur_d = '0;
    else if (tick && dur_q != '1)  dur_d = dur_q + CNT_W'(1);
  end

  assign sym = (dur_q >= DASH_T) ? SYM_DASH : SYM_DOT;

  // Next state, symbol accumulation and output pulses.
  always_comb begin
    state_d     = state_q;
    acc_bits_d  = acc_bits_q;
    acc_len_d   = acc_len_q;
    err_d       = err_q;
    dot_d       = 1'b0;
    dash_d      = 1'b0;
    cv_d        = 1'b0;
    wg_d        = 1'b0;
    code_bits_d = code_bits_q;
    code_len_d  = code_len_q;
    code_err_d  = code_err_q;
    unique case (state_q)
      IDLE: begin
        if (rise_q) state_d = PRESS;
      end
      PRESS: begin
        if (fall_q) begin
          if (dur_q != '0) begin
            dot_d  = (sym == SYM_DOT);
            dash_d = (sym == SYM_DASH);
            if (acc_len_q < MAX_L) begin
              acc_bits_d = acc_bits_q | (MAX_SYMBOLS'(sym) << acc_len_q);
              acc_len_d  = acc_len_q + LEN_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end
          state_d = ((acc_len_d != '0) || err_d) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (dur_q >= LGAP_T) begin
          cv_d        = 1'b1;
          code_bits_d = acc_bits_q;
          code_len_d  = acc_len_q;
          code_err_d  = err_q;
          acc_bits_d  = '0;
          acc_len_d   = '0;
          err_d       = 1'b0;
          state_d     = WGAP;
        end
        // A press on the threshold cycle still starts the next letter.
        if (rise_q) state_d = PRESS;
      end
      WGAP: begin
        if (dur_q >= WGAP_T) begin
          wg_d    = 1'b1;
          state_d = IDLE;
        end
        if (rise_q) state_d = PRESS;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dur_q       <= '0;
      acc_bits_q  <= '0;
      acc_len_q   <= '0;
      err_q       <= 1'b0;
      dot_q       <= 1'b0;
      dash_q      <= 1'b0;
      cv_q        <= 1'b0;
      wg_q        <= 1'b0;
      code_bits_q <= '0;
      code_len_q  <= '0;
      code_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dur_q       <= dur_d;
      acc_bits_q  <= acc_bits_d;
      acc_len_q   <= acc_len_d;
      err_q       <= err_d;
      dot_q       <= dot_d;
      dash_q      <= dash_d;
      cv_q        <= cv_d;
      wg_q        <= wg_d;
      code_bits_q <= code_bits_d;
      code_len_q  <= code_len_d;
      code_err_q  <= code_err_d;
    end
  end

  assign dot        = dot_q;
  assign dash       = dash_q;
  assign code_valid = cv_q;
  assign word_gap   = wg_q;
  assign code_bits  = code_bits_q;
  assign code_len   = code_len_q;
  assign code_err   = code_err_q;

endmodule

// File: tb/tb_morse_letter_decoder.sv
// Directed bench for morse_letter_decoder with short ticks (4 clocks).
module tb_morse_letter_decoder;
  import morse_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       b;
  logic       dot, dash, code_valid, code_err, word_gap;
  logic [3:0] code_bits;
  logic [2:0] code_len;

  morse_letter_decoder #(
    .TICK_CYCLES      (4),
    .DASH_TICKS       (3),
    .LETTER_GAP_TICKS (3),
    .WORD_GAP_TICKS   (7),
    .MAX_SYMBOLS      (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .b          (b),
    .dot        (dot),
    .dash       (dash),
    .code_valid (code_valid),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .code_err   (code_err),
    .word_gap   (word_gap)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge.
  int         n_dot = 0, n_dash = 0, n_cv = 0, n_wg = 0;
  int         cv_cyc = 0, wg_cyc = 0;
  logic [3:0] bits_last = '0, bits_prev = '0;
  logic [2:0] len_last = '0, len_prev = '0;
  logic       err_last = 1'b0, err_prev = 1'b0;

  always @(negedge clk) begin
    if (dot)  n_dot  <= n_dot + 1;
    if (dash) n_dash <= n_dash + 1;
    if (code_valid) begin
      n_cv      <= n_cv + 1;
      cv_cyc    <= cyc;
      bits_prev <= bits_last;
      len_prev  <= len_last;
      err_prev  <= err_last;
      bits_last <= code_bits;
      len_last  <= code_len;
      err_last  <= code_err;
    end
    if (word_gap) begin
      n_wg   <= n_wg + 1;
      wg_cyc <= cyc;
    end
  end

  int n_vec = 0, n_err = 0;
  int d0, s0, c0, w0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int hi, input int lo);
    b = 1'b1;
    repeat (hi) @(negedge clk);
    b = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic snap();
    d0 = n_dot; s0 = n_dash; c0 = n_cv; w0 = n_wg;
  endtask

  task automatic chk_counts(input string tag, input int ed, input int es, input int ec, input int ew);
    chk({tag, "_dots"},   n_dot - d0,  ed);
    chk({tag, "_dashes"}, n_dash - s0, es);
    chk({tag, "_cv"},     n_cv - c0,   ec);
    chk({tag, "_wg"},     n_wg - w0,   ew);
  endtask

  initial begin
    reset_n = 1'b0;
    b       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dot",   dot, 0);
    chk("rst_dash",  dash, 0);
    chk("rst_cv",    code_valid, 0);
    chk("rst_bits",  code_bits, 0);
    chk("rst_len",   code_len, 0);
    chk("rst_err",   code_err, 0);
    chk("rst_wg",    word_gap, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Dot (6 high) then dash (20 high); dot pulse lands on the 4th edge.
    snap();
    b = 1'b1;
    repeat (6) @(negedge clk);
    b = 1'b0;
    repeat (3) @(negedge clk);
    chk("s1_dot_edge3", dot, 0);
    @(negedge clk);
    chk("s1_dot_edge4", dot, 1);
    repeat (2) @(negedge clk);
    press(20, 40);
    chk_counts("s1", 1, 1, 1, 1);
    chk("s1_bits", bits_last, 4'b0010);
    chk("s1_len",  len_last, 2);
    chk("s1_err",  err_last, 0);
    chk("s1_wg_delay", wg_cyc - cv_cyc, 16);

    // Glitches: 2 and 4 cycles both measure zero ticks.
    snap();
    press(2, 30);
    press(4, 30);
    chk_counts("s2", 0, 0, 0, 0);
    chk("s2_state", 32'(dut.state_q), 32'(IDLE));

    // Overflow: five dots into a four-symbol letter.
    snap();
    repeat (4) press(6, 6);
    press(6, 40);
    chk_counts("s3", 5, 0, 1, 1);
    chk("s3_bits", bits_last, 4'b0000);
    chk("s3_len",  len_last, 4);
    chk("s3_err",  err_last, 1);

    // Thresholds: 5-cycle dot, 12-cycle gap stays in letter, 12 dot, 13 dash.
    snap();
    press(5, 12);
    press(12, 6);
    press(13, 40);
    chk_counts("s_bnd", 2, 1, 1, 1);
    chk("s_bnd_bits", bits_last, 4'b0100);
    chk("s_bnd_len",  len_last, 3);
    chk("s_bnd_err",  err_last, 0);

    // E, 14-cycle gap, T: two letters, word gap only after T.
    snap();
    press(6, 14);
    press(20, 40);
    chk_counts("s4", 1, 1, 2, 1);
    chk("s4_len1",  len_prev, 1);
    chk("s4_bits1", bits_prev, 4'b0000);
    chk("s4_len2",  len_last, 1);
    chk("s4_bits2", bits_last, 4'b0001);
    chk("s4_wg_after_t", (wg_cyc > cv_cyc) ? 1 : 0, 1);

    // Press rises exactly on the letter-threshold cycle (13-cycle gap).
    snap();
    press(6, 13);
    press(20, 40);
    chk_counts("s6", 1, 1, 2, 1);
    chk("s6_len1",  len_prev, 1);
    chk("s6_bits1", bits_prev, 4'b0000);
    chk("s6_len2",  len_last, 1);
    chk("s6_bits2", bits_last, 4'b0001);

    // Reset in the gap after two dots: partial letter is discarded.
    snap();
    press(6, 6);
    press(6, 8);
    reset_n = 1'b0;
    #1;
    chk("s5_bits",  code_bits, 0);
    chk("s5_len",   code_len, 0);
    chk("s5_err",   code_err, 0);
    chk("s5_cv",    code_valid, 0);
    chk("s5_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("s5_no_cv", n_cv - c0, 0);
    press(20, 40);
    chk("s5_new_cv",   n_cv - c0, 1);
    chk("s5_new_len",  len_last, 1);
    chk("s5_new_bits", bits_last, 4'b0001);
    chk("s5_new_err",  err_last, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
